// File: rtl/k12a_alu_sequencer.sv
// K12A ALU sequencer: decodes a captured instruction and steps the ALU/register controls, done N+3 (legal) or N+1 (illegal).
// Backpressure: start is only accepted in IDLE; any start while busy or in DONE is dropped.
package k12a_alu_pkg;
  typedef enum logic {
    ALU_OPERAND_SEL_B    = 1'b0,
    ALU_OPERAND_SEL_INST = 1'b1
  } alu_operand_sel_t;
endpackage

module k12a_alu_sequencer
  import k12a_alu_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [15:0]      inst,
  input  logic             alu_condition,
  output logic [15:0]      inst_q,
  output alu_operand_sel_t alu_operand_sel,
  output logic             alu_subtract,
  output logic             alu_load,
  output logic             a_load,
  output logic             b_load,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             skip,
  output logic [7:0]       retired_count
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EXEC  = 3'd1,
    ST_WRITE = 3'd2,
    ST_COND  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic accept;
  logic new_legal;
  logic cls_cmp;
  logic cls_imm;
  logic entering_done;

  // Legal classes are 0x0..0x3, so only the top two class bits decide legality.
  assign new_legal     = (inst[15:14] == 2'b00);
  assign accept        = (state_q == ST_IDLE) && start;
  assign cls_cmp       = inst_q[13];
  assign cls_imm       = inst_q[12];
  assign entering_done = (state_d == ST_DONE) && (state_q != ST_DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = new_legal ? ST_EXEC : ST_DONE;
      ST_EXEC:  state_d = cls_cmp ? ST_COND : ST_WRITE;
      ST_WRITE: state_d = ST_DONE;
      ST_COND:  state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      inst_q        <= 16'h0000;
      skip          <= 1'b0;
      error         <= 1'b0;
      retired_count <= 8'h00;
    end else begin
      state_q <= state_d;
      if (accept) inst_q <= inst;
      if (state_q == ST_COND) skip <= alu_condition ^ inst_q[11];
      // Only the IDLE->DONE shortcut is taken by illegal classes.
      if (entering_done) begin
        error <= (state_q == ST_IDLE);
        if (state_q != ST_IDLE) retired_count <= retired_count + 8'd1;
      end
    end
  end

  always_comb begin
    alu_operand_sel = ALU_OPERAND_SEL_B;
    alu_subtract    = 1'b0;
    alu_load        = 1'b0;
    a_load          = 1'b0;
    b_load          = 1'b0;
    busy            = (state_q != ST_IDLE);
    done            = (state_q == ST_DONE);
    if ((state_q == ST_EXEC) || (state_q == ST_WRITE) || (state_q == ST_COND)) begin
      alu_operand_sel = cls_imm ? ALU_OPERAND_SEL_INST : ALU_OPERAND_SEL_B;
      alu_subtract    = cls_cmp || (inst_q[10:8] == 3'h5);
    end
    if (state_q == ST_WRITE) begin
      alu_load = 1'b1;
      a_load   = ~inst_q[11];
      b_load   = inst_q[11];
    end
  end

endmodule

// File: tb/tb_k12a_alu_sequencer.sv
// Directed table-driven bench for k12a_alu_sequencer plus hand sequences for busy-ignore, wrap and reset.
module tb_k12a_alu_sequencer;
  import k12a_alu_pkg::*;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             start;
  logic [15:0]      inst;
  logic             alu_condition;
  logic [15:0]      inst_q;
  alu_operand_sel_t alu_operand_sel;
  logic             alu_subtract, alu_load, a_load, b_load, busy, done, error, skip;
  logic [7:0]       retired_count;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_cnt;

  k12a_alu_sequencer dut (
    .clock(clock), .reset_n(reset_n), .start(start), .inst(inst),
    .alu_condition(alu_condition), .inst_q(inst_q), .alu_operand_sel(alu_operand_sel),
    .alu_subtract(alu_subtract), .alu_load(alu_load), .a_load(a_load), .b_load(b_load),
    .busy(busy), .done(done), .error(error), .skip(skip), .retired_count(retired_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] inst;
    logic        cond;
    logic        legal;
    logic        is_alu;
    logic        sel;
    logic        sub;
    logic        a_ld;
    logic        b_ld;
    logic        skip;
    logic        err;
  } vec_t;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " alu_load"}, alu_load, 0);
    check({tag, " a_load"}, a_load, 0);
    check({tag, " b_load"}, b_load, 0);
    check({tag, " sub"}, alu_subtract, 0);
    check({tag, " sel"}, alu_operand_sel, ALU_OPERAND_SEL_B);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    start = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    exp_cnt = 8'h00;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    inst = v.inst;
    alu_condition = v.cond;
    start = 1'b1;
    step();
    start = 1'b0;
    check({t, " inst_q"}, inst_q, v.inst);
    if (v.legal) begin
      exp_cnt = exp_cnt + 8'd1;
      check({t, " exec busy"}, busy, 1);
      check({t, " exec done"}, done, 0);
      check({t, " exec sel"}, alu_operand_sel, v.sel);
      check({t, " exec sub"}, alu_subtract, v.sub);
      check({t, " exec alu_load"}, alu_load, 0);
      check({t, " exec ab_load"}, {a_load, b_load}, 2'b00);
      step();
      check({t, " s2 done"}, done, 0);
      check({t, " s2 sel"}, alu_operand_sel, v.sel);
      check({t, " s2 sub"}, alu_subtract, v.sub);
      check({t, " s2 alu_load"}, alu_load, v.is_alu);
      check({t, " s2 a_load"}, a_load, v.a_ld);
      check({t, " s2 b_load"}, b_load, v.b_ld);
      step();
    end
    check({t, " done"}, done, 1);
    check({t, " done busy"}, busy, 1);
    check({t, " done alu_load"}, alu_load, 0);
    check({t, " error"}, error, v.err);
    check({t, " skip"}, skip, v.skip);
    check({t, " retired"}, retired_count, exp_cnt);
    step();
    check_idle_outputs({t, " idle"});
  endtask

  task automatic run_quick(input logic [15:0] i);
    int n;
    inst = i;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!done && n < 10) begin
      step();
      n++;
    end
    if (!done) check("quick done timeout", 0, 1);
    step();
  endtask

  vec_t vecs[12];

  initial begin
    //             inst      cnd leg alu sel sub a   b   skp err
    vecs[0]  = '{16'h0400, 1'b0, 1, 1, 0, 0, 1, 0, 0, 0};
    vecs[1]  = '{16'h1D05, 1'b0, 1, 1, 1, 1, 0, 1, 0, 0};
    vecs[2]  = '{16'h2400, 1'b1, 1, 0, 0, 1, 0, 0, 1, 0};
    vecs[3]  = '{16'h3C00, 1'b1, 1, 0, 1, 1, 0, 0, 0, 0};
    vecs[4]  = '{16'h9000, 1'b0, 0, 0, 0, 0, 0, 0, 0, 1};
    vecs[5]  = '{16'h0500, 1'b0, 1, 1, 0, 1, 1, 0, 0, 0};
    vecs[6]  = '{16'h2800, 1'b0, 1, 0, 0, 1, 0, 0, 1, 0};
    vecs[7]  = '{16'hF123, 1'b0, 0, 0, 0, 0, 0, 0, 1, 1};
    vecs[8]  = '{16'h1A7F, 1'b0, 1, 1, 1, 0, 0, 1, 1, 0};
    vecs[9]  = '{16'h3000, 1'b0, 1, 0, 1, 1, 0, 0, 0, 0};
    vecs[10] = '{16'h4000, 1'b0, 0, 0, 0, 0, 0, 0, 0, 1};
    vecs[11] = '{16'h0100, 1'b0, 1, 1, 0, 0, 1, 0, 0, 0};

    start = 1'b0;
    inst = 16'h0000;
    alu_condition = 1'b0;
    reset_n = 1'b0;
    do_reset();

    check_idle_outputs("reset");
    check("reset inst_q", inst_q, 16'h0000);
    check("reset error", error, 0);
    check("reset skip", skip, 0);
    check("reset retired", retired_count, 8'h00);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // start with an illegal class during EXEC/WRITE/DONE of 0x0100 must be dropped
    inst = 16'h0100;
    start = 1'b1;
    step();
    exp_cnt = exp_cnt + 8'd1;
    inst = 16'h4000;
    step();
    check("ign write inst_q", inst_q, 16'h0100);
    check("ign write alu_load", alu_load, 1);
    step();
    check("ign done", done, 1);
    check("ign done error", error, 0);
    check("ign done inst_q", inst_q, 16'h0100);
    step();
    check("ign idle busy", busy, 0);
    check("ign idle inst_q", inst_q, 16'h0100);
    check("ign retired", retired_count, exp_cnt);
    start = 1'b0;
    step();
    check("ign no accept", busy, 0);

    // 256 legal instructions from reset wrap the counter back to zero
    do_reset();
    for (int i = 0; i < 256; i++) begin
      run_quick(16'h0400);
      if (i == 254) check("wrap at 255", retired_count, 8'hFF);
    end
    check("wrap to zero", retired_count, 8'h00);

    // reset while in WRITE kills the pending register load
    run_quick(16'h9000);
    check("pre-reset error", error, 1);
    inst = 16'h0800;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("pre-reset b_load", b_load, 1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check_idle_outputs("wreset");
    check("wreset inst_q", inst_q, 16'h0000);
    check("wreset error", error, 0);
    check("wreset skip", skip, 0);
    check("wreset retired", retired_count, 8'h00);
    step();
    check("wreset stays idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/k12a_alu_sequencer.md
K12A_ALU_SEQUENCER -- requirements
Module: k12a_alu_sequencer

Interface
REQ-001 SHALL have `clock`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have `reset_n`, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of `clock`.
REQ-003 SHALL have `start`, input, 1 bit: request to execute `inst`; accepted only in IDLE.
REQ-004 SHALL have `inst`, input, 16 bits: instruction word, captured into an internal register on start acceptance.
REQ-005 SHALL have `alu_condition`, input, 1 bit: condition flag from the ALU for the opcode in `inst_q[10:8]`.
REQ-006 SHALL have `inst_q`, output, 16 bits: the captured instruction; drives the ALU `inst` input.
REQ-007 SHALL have `alu_operand_sel`, output, type alu_operand_sel_t: ALU second-operand select.
REQ-008 SHALL have `alu_subtract`, output, 1 bit: ALU subtract control.
REQ-009 SHALL have `alu_load`, output, 1 bit: enables the ALU result onto `data_bus`.
REQ-010 SHALL have `a_load` and `b_load`, outputs, 1 bit each: write enables for register A and register B from `data_bus`.
REQ-011 SHALL have `busy`, output, 1 bit: high in every state except IDLE.
REQ-012 SHALL have `done`, output, 1 bit: one-cycle completion pulse.
REQ-013 SHALL have `error`, output, 1 bit: the last completed instruction had an illegal opcode.
REQ-014 SHALL have `skip`, output, 1 bit: result of the last compare-skip instruction.
REQ-015 SHALL have `retired_count`, output, 8 bits: count of legally completed instructions.

Function
REQ-016 Decoding SHALL use `inst_q[15:12]` as the class field:
- 0x0: ALU operation, register operand (ALU_OPERAND_SEL_B).
- 0x1: ALU operation, immediate operand (ALU_OPERAND_SEL_INST).
- 0x2: compare-skip, register operand.
- 0x3: compare-skip, immediate operand.
- 0x4 to 0xF: illegal.
REQ-017 The FSM SHALL have the states IDLE, EXEC, WRITE, COND and DONE, with transitions:
- IDLE to EXEC on `start` with a legal class.
- IDLE to DONE on `start` with an illegal class.
- EXEC to WRITE for ALU classes.
- EXEC to COND for compare classes.
- WRITE to DONE.
- COND to DONE.
- DONE to IDLE.
REQ-018 `inst_q` SHALL load `inst` only when `start` is accepted in IDLE, and SHALL hold otherwise.
REQ-019 `start` outside IDLE SHALL be ignored: no capture, no effect on state or outputs.
REQ-020 In EXEC, WRITE and COND, `alu_operand_sel` SHALL follow the class. In all other states it SHALL be ALU_OPERAND_SEL_B.
REQ-021 `alu_subtract` SHALL be 1 in EXEC, WRITE and COND when:
- the class is compare-skip; or
- the class is ALU and `inst_q[10:8]` = 3'h5.
It SHALL be 0 otherwise.
REQ-022 `alu_load` SHALL be 1 only in WRITE.
REQ-023 In WRITE, `a_load` SHALL equal ~`inst_q[11]` and `b_load` SHALL equal `inst_q[11]`. Both SHALL be 0 in every other state.
REQ-024 In COND, `skip` SHALL register `alu_condition` XOR `inst_q[11]` (bit 11 inverts the sense), and SHALL hold until the next COND.
REQ-025 `done` SHALL be 1 exactly in DONE. All outputs SHALL be Moore outputs decoded from registered state.
REQ-026 On entry to DONE, `error` SHALL update: 1 if the class is illegal, else 0. `error` SHALL hold until the next DONE.
REQ-027 `retired_count` SHALL increment by 1 on entry to DONE for legal classes only, wrapping 0xFF to 0x00.
REQ-028 Latency from the `start`-accept edge N SHALL be:
- legal class: `done` high in cycle N+3;
- illegal class: `done` high in cycle N+1.
REQ-029 `start` asserted in the DONE cycle SHALL be ignored. The earliest re-accept SHALL be the first IDLE cycle.

Reset
REQ-030 While `reset_n` = 0 at a rising edge, the block SHALL be set as follows:
- state = IDLE;
- `inst_q` = 16'h0000;
- `skip`, `error` = 0;
- `retired_count` = 8'h00.
REQ-031 After that reset edge, the outputs SHALL be:
- `alu_load`, `a_load`, `b_load`, `alu_subtract`, `busy`, `done` = 0;
- `alu_operand_sel` = ALU_OPERAND_SEL_B.
REQ-032 Reset SHALL override `start` and any in-progress instruction. A reset in WRITE SHALL produce no `a_load`/`b_load` pulse on the next cycle.

Verification
REQ-033 Register ADD: `inst`=16'h0400, pulse `start` ->
- EXEC: sel=B, sub=0.
- WRITE: `alu_load`=1, `a_load`=1, `b_load`=0.
- `done` in cycle N+3; `retired_count`=1.
REQ-034 Immediate SUB to B: `inst`=16'h1D05 ->
- sel=INST and `alu_subtract`=1 through EXEC and WRITE.
- WRITE: `b_load`=1, `a_load`=0.
REQ-035 Compare-skip: `inst`=16'h2400 with `alu_condition`=1 in COND -> `skip`=1. Then `inst`=16'h3C00 with `alu_condition`=1 -> `skip`=0. `alu_load` stays 0 throughout.
REQ-036 Illegal opcode: `inst`=16'h9000 -> `done` in cycle N+1, `error`=1, `retired_count` unchanged. A following legal instruction clears `error`.
REQ-037 Busy/ignore: assert `start` with `inst`=16'h4000 during EXEC of 16'h0100 -> it is ignored; `inst_q` stays 16'h0100 and `error` stays 0.
REQ-038 Wrap and reset: run 256 legal instructions -> `retired_count` returns to 8'h00. Drop `reset_n` in WRITE -> next cycle IDLE with all outputs at REQ-030/REQ-031 values.
